interval_timer: RTL and testbench

- Countdown timer directly downstream of the time-parameter register block in the traffic light controller.
- On a start request from the main FSM, it drives `selector` to the parameter block and waits for the registered `t_value`.
- It then loads the value, or double it for the main-street base interval.
- It counts whole seconds on the 1 Hz enable and pulses `expired` back to the FSM.

---
 rtl/traffic_timer_pkg.sv | 30 +++
 rtl/sec_down_counter.sv | 54 +++++
 rtl/interval_timer.sv | 161 ++++++++++++++++
 tb/tb_interval_timer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_timer_pkg.sv
// -----------------------------------------------------------------------------
// traffic_timer_pkg
// Shared definitions for the traffic light interval timer:
//   - parameter-block select codes driven on `selector`
//   - default widths of the parameter value and of the countdown register
//   - the interval timer FSM state encoding
// -----------------------------------------------------------------------------
package traffic_timer_pkg;

  // Width of t_value coming from the parameter block.
  localparam int T_W   = 4;
  // Countdown width; must hold the doubled maximum 2*15 = 30.
  localparam int CNT_W = 5;

  // Select codes understood by the time-parameter register block.
  localparam logic [1:0] BASE_SELECT = 2'b00;
  localparam logic [1:0] EXT_SELECT  = 2'b01;
  localparam logic [1:0] YEL_SELECT  = 2'b10;
  // 2'b11 is not a real interval; the parameter block answers it with zero.
  localparam logic [1:0] ZERO_SELECT = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    COUNT = 3'd4
  } timer_state_e;

endpackage

// File: rtl/sec_down_counter.sv
// -----------------------------------------------------------------------------
// sec_down_counter
// Countdown register for the interval timer. Priority: clear > load > tick.
// A tick at zero leaves the value at zero (no wrap).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset, value -> 0
//   clear       in   force value to 0
//   load        in   load load_value
//   load_value  in   W  value to load
//   tick        in   decrement by one (ignored at 0)
//   value       out  W  current count
//   at_one      out  count equals 1 (next tick completes the interval)
// -----------------------------------------------------------------------------
module sec_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         at_one
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = load_value;
    end else if (tick && (value_q != '0)) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign at_one = (value_q == W'(1));

endmodule

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Countdown timer fed by the time-parameter register block of the traffic
// light controller. A start request selects an interval on `selector`, waits
// for the registered `t_value`, loads it (optionally doubled) and counts it
// down on the 1 Hz enable, pulsing `expired` when done.
//
// Build option: define TIMER_PAUSE_EN to add the `pause` input, which freezes
// the countdown while in COUNT.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start_timer    in   one-cycle start/restart request
//   interval       in   2  interval select (BASE/EXT/YEL, 11 = zero time)
//   double_len     in   sampled with start_timer; 1 = load 2*t_value
//   one_hz_enable  in   one-cycle pulse per second
//   t_value        in   T_W registered value from the parameter block
//   pause          in   (TIMER_PAUSE_EN only) hold the count in COUNT
//   selector       out  2  registered select to the parameter block
//   expired        out  one-cycle completion pulse
//   busy           out  high from the cycle after start until expired
//   remaining      out  CNT_W current countdown value
//
// Handshake: start_timer is a fire-and-forget request (no ready); it is
// accepted in every state and always wins over a same-cycle tick. expired is
// a single-cycle pulse issued only for an interval that ran to completion;
// busy is the level view of the same transaction and falls with expired.
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int CNT_W = 5,
  parameter int T_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_timer,
  input  logic [1:0]       interval,
  input  logic             double_len,
  input  logic             one_hz_enable,
  input  logic [T_W-1:0]   t_value,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       selector,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  import traffic_timer_pkg::*;

  timer_state_e state_q, state_d;
  logic [1:0]   selector_q, selector_d;
  logic         double_q, double_d;
  logic         expired_q, expired_d;
  logic         busy_q, busy_d;

  logic             ctr_clear;
  logic             ctr_load;
  logic             ctr_tick;
  logic             ctr_at_one;
  logic [CNT_W-1:0] ctr_value;
  logic [T_W:0]     t_scaled;
  logic [CNT_W-1:0] load_value;
  logic             tick_ok;

  assign t_scaled   = double_q ? {t_value, 1'b0} : {1'b0, t_value};
  assign load_value = CNT_W'(t_scaled);

`ifdef TIMER_PAUSE_EN
  assign tick_ok = one_hz_enable & ~pause;
`else
  assign tick_ok = one_hz_enable;
`endif

  always_comb begin
    state_d    = state_q;
    selector_d = selector_q;
    double_d   = double_q;
    expired_d  = 1'b0;
    busy_d     = busy_q;
    ctr_clear  = 1'b0;
    ctr_load   = 1'b0;
    ctr_tick   = 1'b0;

    if (start_timer) begin
      // Restart from anywhere: the running count is abandoned and holds its
      // value until the new LOAD; no decrement and no expired this cycle.
      selector_d = interval;
      double_d   = double_len;
      busy_d     = 1'b1;
      state_d    = SEL;
    end else begin
      unique case (state_q)
        IDLE: ;
        // Parameter block samples selector here.
        SEL:  state_d = WAIT;
        // Its registered answer becomes valid in LOAD.
        WAIT: state_d = LOAD;
        LOAD: begin
          if (load_value == '0) begin
            // Zero-length interval finishes without counting.
            ctr_clear = 1'b1;
            expired_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            ctr_load = 1'b1;
            state_d  = COUNT;
          end
        end
        COUNT: begin
          if (tick_ok) begin
            ctr_tick = 1'b1;
            if (ctr_at_one) begin
              expired_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      selector_q <= 2'b00;
      double_q   <= 1'b0;
      expired_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      double_q   <= double_d;
      expired_q  <= expired_d;
      busy_q     <= busy_d;
    end
  end

  sec_down_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (ctr_clear),
    .load       (ctr_load),
    .load_value (load_value),
    .tick       (ctr_tick),
    .value      (ctr_value),
    .at_one     (ctr_at_one)
  );

  assign selector  = selector_q;
  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = ctr_value;

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
// Directed bench for interval_timer. A small parameter-block model answers
// `selector` with a registered t_value (BASE=6, EXT=3, YEL=2, 11 -> 0).
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_interval_timer;
  import traffic_timer_pkg::*;

  localparam int CW = 5;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start_timer   = 1'b0;
  logic [1:0]    interval      = 2'b00;
  logic          double_len    = 1'b0;
  logic          one_hz_enable = 1'b0;
  logic [TW-1:0] t_value;
`ifdef TIMER_PAUSE_EN
  logic          pause         = 1'b0;
`endif
  logic [1:0]    selector;
  logic          expired;
  logic          busy;
  logic [CW-1:0] remaining;

  interval_timer #(
    .CNT_W (CW),
    .T_W   (TW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_timer   (start_timer),
    .interval      (interval),
    .double_len    (double_len),
    .one_hz_enable (one_hz_enable),
    .t_value       (t_value),
`ifdef TIMER_PAUSE_EN
    .pause         (pause),
`endif
    .selector      (selector),
    .expired       (expired),
    .busy          (busy),
    .remaining     (remaining)
  );

  // ---------------- parameter block model ----------------
  logic [TW-1:0] p_base = 4'd6;
  logic [TW-1:0] p_ext  = 4'd3;
  logic [TW-1:0] p_yel  = 4'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_value <= '0;
    end else begin
      case (selector)
        BASE_SELECT: t_value <= p_base;
        EXT_SELECT:  t_value <= p_ext;
        YEL_SELECT:  t_value <= p_yel;
        default:     t_value <= '0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_seen = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns in the SEL cycle.
  task automatic start(input logic [1:0] iv, input logic dbl);
    interval    = iv;
    double_len  = dbl;
    start_timer = 1'b1;
    cycle();
    start_timer = 1'b0;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    cycle();
    one_hz_enable = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset defaults
    repeat (3) cycle();
    check("rst_selector", 32'(selector), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_remaining", 32'(remaining), 0);
    reset_n = 1'b1;
    cycle();

    // 1: BASE doubled -> 12, tick every 10 cycles, reprogram mid-count
    start(BASE_SELECT, 1'b1);
    check("t1_selector", 32'(selector), 0);
    check("t1_busy_after_start", 32'(busy), 1);
    cycle();
    cycle();
    cycle();
    check("t1_loaded", 32'(remaining), 12);
    exp_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      repeat (9) begin
        cycle();
        if (expired) exp_seen++;
      end
      if (k == 6) p_base = 4'd9;
      tick();
      check("t1_remaining", 32'(remaining), 32'(12 - k));
      if (k < 12) begin
        check("t1_no_expire", 32'(expired), 0);
      end else begin
        check("t1_expired", 32'(expired), 1);
        check("t1_busy_drop", 32'(busy), 0);
      end
    end
    check("t1_early_expire_count", 32'(exp_seen), 0);
    cycle();
    check("t1_expired_one_cycle", 32'(expired), 0);
    p_base = 4'd6;

    // 2: YEL, tick during LOAD ignored, sequence 2,1,0
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd0);
    start(YEL_SELECT, 1'b0);
    check("t2_selector", 32'(selector), 2);
    cycle();
    cycle();
    one_hz_enable = 1'b1;
    cycle();
    one_hz_enable = 1'b0;
    check("t2_load_tick_ignored", 32'(remaining), 32'(exp_q.pop_front()));
    tick();
    check("t2_rem_after_tick1", 32'(remaining), 32'(exp_q.pop_front()));
    check("t2_no_expire", 32'(expired), 0);
    tick();
    check("t2_rem_after_tick2", 32'(remaining), 32'(exp_q.pop_front()));
    check("t2_expired", 32'(expired), 1);
    check("t2_busy_drop", 32'(busy), 0);
    cycle();
    check("t2_expired_clear", 32'(expired), 0);
    check("t2_selector_held", 32'(selector), 2);

    // 3: interval 11 -> zero time, expired 4 cycles after start
    start(ZERO_SELECT, 1'b0);
    check("t3_c1_expired", 32'(expired), 0);
    cycle();
    check("t3_c2_expired", 32'(expired), 0);
    cycle();
    check("t3_c3_expired", 32'(expired), 0);
    cycle();
    check("t3_c4_expired", 32'(expired), 1);
    check("t3_busy", 32'(busy), 0);
    check("t3_remaining", 32'(remaining), 0);
    cycle();
    check("t3_expired_clear", 32'(expired), 0);

    // 4: retrigger with same-cycle tick while EXT counts at 2
    start(EXT_SELECT, 1'b0);
    cycle();
    cycle();
    cycle();
    check("t4_loaded", 32'(remaining), 3);
    tick();
    check("t4_rem2", 32'(remaining), 2);
    interval      = YEL_SELECT;
    double_len    = 1'b0;
    start_timer   = 1'b1;
    one_hz_enable = 1'b1;
    cycle();
    start_timer   = 1'b0;
    one_hz_enable = 1'b0;
    check("t4_no_decrement", 32'(remaining), 2);
    check("t4_no_expire", 32'(expired), 0);
    check("t4_busy", 32'(busy), 1);
    check("t4_selector", 32'(selector), 2);
    cycle();
    check("t4_wait_no_expire", 32'(expired), 0);
    cycle();
    cycle();
    check("t4_reload", 32'(remaining), 2);
    tick();
    check("t4_counting", 32'(remaining), 1);
    tick();
    check("t4_expired", 32'(expired), 1);

    // 5: asynchronous reset mid-count
    start(BASE_SELECT, 1'b0);
    cycle();
    cycle();
    cycle();
    check("t5_loaded", 32'(remaining), 6);
    tick();
    check("t5_rem5", 32'(remaining), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_remaining", 32'(remaining), 0);
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_expired", 32'(expired), 0);
    check("t5_async_selector", 32'(selector), 0);
    cycle();
    reset_n = 1'b1;
    exp_seen = 0;
    repeat (8) begin
      tick();
      if (expired) exp_seen++;
    end
    check("t5_no_expire_after_release", 32'(exp_seen), 0);
    check("t5_idle_busy", 32'(busy), 0);
    check("t5_idle_remaining", 32'(remaining), 0);

`ifdef TIMER_PAUSE_EN
    // 6: pause holds the count
    start(BASE_SELECT, 1'b0);
    cycle();
    cycle();
    cycle();
    check("t6_loaded", 32'(remaining), 6);
    tick();
    tick();
    check("t6_rem4", 32'(remaining), 4);
    pause = 1'b1;
    repeat (3) begin
      tick();
      check("t6_paused_hold", 32'(remaining), 4);
    end
    pause = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t6_rem", 32'(remaining), 32'(4 - k));
      check("t6_expired", 32'(expired), (k == 4) ? 32'd1 : 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
